// File: rtl/mipsfpga_ahb_scratchpad.sv
// AHB-Lite scratchpad slave: a word-organised RAM that supports byte, halfword and word
// transfers, a fixed number of wait states per OKAY transfer, and the two-cycle ERROR response.
module mipsfpga_ahb_scratchpad #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e        state_q;
  logic [2:0]    wait_cnt_q;
  logic          hreadyout_q;
  logic          hresp_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [31:0]   mem_q [2**AW];

  logic          accept;
  logic          illegal;
  logic          commit;
  logic [3:0]    lane_en;
  logic [AW-1:0] word_idx;
  logic          unused_bits;

  // Upper address bits and HTRANS[0] never influence the response (SEQ behaves as NONSEQ).
  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    illegal = 1'b0;
    case (HSIZE)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = HADDR[0];
      3'b010:  illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all decode a new address phase identically.
          if (accept) begin
            addr_q  <= HADDR[AW+1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (illegal) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (HAS_WAIT) begin
              state_q     <= S_WAIT;
              wait_cnt_q  <= WAIT_LOAD;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'b00:   lane_en[addr_q[1:0]] = 1'b1;
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  assign word_idx = addr_q[AW+1:2];
  assign commit   = (state_q == S_DATA) && write_q;

  // NOTE: the RAM array has no reset; clearing it would defeat RAM inference and
  // its contents are undefined until written.
  always_ff @(posedge HCLK) begin
    for (int k = 0; k < 4; k++) begin
      if (commit && lane_en[k]) begin
        mem_q[word_idx][8*k +: 8] <= HWDATA[8*k +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_mipsfpga_ahb_scratchpad.sv
// Self-checking bench: three scratchpads (0, 3 and 2 wait states) driven by directed and
// random AHB transfers, checked cycle by cycle against a byte-level memory model.
module tb_mipsfpga_ahb_scratchpad;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [2:0]  hreadyout;
  logic [2:0]  hresp;
  logic [31:0] hrdata [3];

  int          n_checks;
  int          n_errors;
  int          ws_of [3] = '{0, 3, 2};
  op_t         op_q [$];
  logic [31:0] model [int];

  mipsfpga_ahb_scratchpad #(.AW(10), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  mipsfpga_ahb_scratchpad #(.AW(10), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  mipsfpga_ahb_scratchpad #(.AW(10), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input op_t o);
    if (o.size > 3'd2) return 1'b1;
    return (o.addr % (32'd1 << o.size)) != 0;
  endfunction

  function automatic int key_of(input int d, input logic [31:0] addr);
    return d * 4096 + int'(addr[11:2]);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    int key = key_of(d, addr);
    return model.exists(key) ? model[key] : 32'hxxxx_xxxx;
  endfunction

  // A transfer of 2**size bytes starting at byte offset addr[1:0] overwrites those bytes.
  task automatic model_write(input int d, input op_t o);
    int          key = key_of(d, o.addr);
    logic [31:0] w   = model.exists(key) ? model[key] : 32'h0;
    for (int b = 0; b < (1 << o.size); b++) begin
      int lane = int'(o.addr[1:0]) + b;
      w[lane*8 +: 8] = o.wdata[lane*8 +: 8];
    end
    model[key] = w;
  endtask

  task automatic add_op(input bit sel, input logic [1:0] trans, input bit write,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.sel = sel; o.trans = trans; o.write = write;
    o.size = size; o.addr = addr; o.wdata = wdata;
    op_q.push_back(o);
  endtask

  task automatic drive_idle();
    hsel   = '0;
    htrans = 2'b00;
    haddr  = $urandom;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  // Runs the queued transfers on DUT d; expected handshake per transfer:
  // OKAY = ws cycles not-ready then one ready cycle, ERROR = (0,1) then (1,1).
  task automatic run_ops(input int d);
    op_t         dp;
    op_t         o;
    bit          dp_valid = 1'b0;
    int          dp_cycle = 0;
    int          budget   = 5000;
    bit          dp_err;
    bit          exp_rdy;
    bit          exp_rsp;
    logic [31:0] exp_rd;
    while ((op_q.size() > 0 || dp_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
      exp_rdy = 1'b1;
      exp_rsp = 1'b0;
      exp_rd  = 32'h0;
      dp_err  = 1'b0;
      if (dp_valid) begin
        dp_err = is_illegal(dp);
        if (dp_err) begin
          exp_rdy = (dp_cycle == 1);
          exp_rsp = 1'b1;
        end else begin
          exp_rdy = (dp_cycle == ws_of[d]);
          if (exp_rdy && !dp.write) exp_rd = model_read(d, dp.addr);
        end
      end
      check($sformatf("d%0d hreadyout", d), 32'(hreadyout[d]), 32'(exp_rdy));
      check($sformatf("d%0d hresp", d), 32'(hresp[d]), 32'(exp_rsp));
      check($sformatf("d%0d hrdata", d), hrdata[d], exp_rd);
      hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom;
      if (exp_rdy) begin
        if (dp_valid && !dp_err && dp.write) model_write(d, dp);
        dp_valid = 1'b0;
        if (op_q.size() > 0) begin
          o      = op_q.pop_front();
          hsel   = '0;
          hsel[d] = o.sel;
          htrans = o.trans;
          haddr  = o.addr;
          hsize  = o.size;
          hwrite = o.write;
          if (o.sel && o.trans[1]) begin
            dp       = o;
            dp_valid = 1'b1;
            dp_cycle = 0;
          end
        end else begin
          drive_idle();
        end
      end else begin
        drive_idle();
        dp_cycle++;
      end
    end
    check($sformatf("d%0d cycle budget left", d), 32'(budget > 0), 32'd1);
    op_q.delete();
  endtask

  task automatic prefill(input int d);
    for (int w = 0; w < 16; w++) add_op(1'b1, 2'b10, 1'b1, 3'b010, 32'(w * 4), $urandom);
    run_ops(d);
  endtask

  task automatic random_ops(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      add_op($urandom_range(0, 9) != 0, 2'($urandom), 1'($urandom), size, addr, $urandom);
    end
    for (int w = 0; w < 16; w++) add_op(1'b1, 2'b11, 1'b0, 3'b010, 32'(w * 4), $urandom);
    run_ops(d);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    hwdata   = '0;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'h0);
    end
    rst_n = 1'b1;

    // Zero wait states: pipelining, lane merging, errors and ignored cycles.
    prefill(0);
    add_op(1, 2'b10, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    add_op(1, 2'b10, 0, 3'b010, 32'h10, 32'h0);
    add_op(1, 2'b10, 1, 3'b010, 32'h10, 32'h1122_3344);
    add_op(1, 2'b10, 1, 3'b000, 32'h11, 32'h5A5A_AA5A);
    add_op(1, 2'b10, 0, 3'b010, 32'h10, 32'h0);
    add_op(1, 2'b11, 1, 3'b001, 32'h12, 32'h5566_A5A5);
    add_op(1, 2'b10, 0, 3'b010, 32'h10, 32'h0);
    add_op(1, 2'b10, 1, 3'b010, 32'h06, 32'hFFFF_FFFF);
    add_op(1, 2'b10, 1, 3'b001, 32'h03, 32'hFFFF_FFFF);
    add_op(1, 2'b10, 1, 3'b011, 32'h08, 32'hFFFF_FFFF);
    add_op(1, 2'b10, 0, 3'b010, 32'h04, 32'h0);
    add_op(1, 2'b10, 0, 3'b010, 32'h00, 32'h0);
    add_op(1, 2'b01, 1, 3'b010, 32'h20, 32'h0BAD_0BAD);
    add_op(0, 2'b10, 1, 3'b010, 32'h24, 32'h0BAD_0BAD);
    add_op(1, 2'b00, 1, 3'b010, 32'h20, 32'h0BAD_0BAD);
    add_op(1, 2'b10, 0, 3'b010, 32'h20, 32'h0);
    add_op(1, 2'b10, 0, 3'b010, 32'h24, 32'h0);
    run_ops(0);
    random_ops(0, 200);

    // Three wait states: back-to-back reads with no idle gap.
    prefill(1);
    add_op(1, 2'b10, 0, 3'b010, 32'h00, 32'h0);
    add_op(1, 2'b10, 0, 3'b010, 32'h04, 32'h0);
    add_op(1, 2'b10, 1, 3'b001, 32'h06, 32'h1234_0000);
    add_op(1, 2'b10, 0, 3'b010, 32'h04, 32'h0);
    run_ops(1);
    random_ops(1, 150);

    // Two wait states: reset during the wait of a write abandons it.
    prefill(2);
    add_op(1, 2'b10, 1, 3'b010, 32'h08, 32'h1234_5678);
    run_ops(2);
    @(negedge clk);
    hsel = 3'b100; htrans = 2'b10; haddr = 32'h08; hsize = 3'b010; hwrite = 1'b1;
    @(negedge clk);
    check("d2 wait before reset", 32'(hreadyout[2]), 32'd0);
    drive_idle();
    hwdata = 32'hCAFE_F00D;
    #2 rst_n = 1'b0;
    #1;
    check("d2 async reset hreadyout", 32'(hreadyout[2]), 32'd1);
    check("d2 async reset hresp", 32'(hresp[2]), 32'd0);
    check("d2 async reset hrdata", hrdata[2], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    add_op(1, 2'b10, 0, 3'b010, 32'h08, 32'h0);
    run_ops(2);
    random_ops(2, 150);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
